axi_slave_gen2: RTL and testbench

AXI_SLAVE_GEN2 -- requirements
Module: axi_slave_gen2

---
 rtl/axi_slave_pkg.sv | 9 +
 rtl/sync_fifo.sv | 36 +++
 rtl/axi_slave_gen2.sv | 132 +++++++++++++
 tb/tb_axi_slave_gen2.sv | 379 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_slave_pkg.sv
// axi_slave_pkg: shared FSM state encoding and frame flag positions for axi_slave_gen2.
package axi_slave_pkg;
    typedef enum logic [2:0] {IDLE, WCMD, WDATA, RCMD, RSEND} state_t;
    // Flag field sits above {addr,data} in each frame; offsets are within that 3-bit field.
    localparam int FLAG_WIDTH = 3;
    localparam int SOF_OFS    = 2;
    localparam int EOF_OFS    = 1;
    localparam int WR_OFS     = 0;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: show-ahead synchronous FIFO; push ignored when full, pop ignored when empty.
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  full,
    output logic                  empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wp, rp;
    logic do_push, do_pop;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign empty   = wp == rp;
    assign full    = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign dout    = mem[rp[AW-1:0]];
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop) rp <= rp + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/axi_slave_gen2.sv
// axi_slave_gen2: AXI-like slave that turns aw/w and ar bursts into per-beat frames
// split at column wrap, and tags returned array reads with rlast.
module axi_slave_gen2
    import axi_slave_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 20,
    parameter int AXI_DATA_WIDTH = 64,
    parameter int AXI_LEN_WIDTH  = 6,
    parameter int COL_WIDTH      = 6,
    parameter int CMD_DEPTH      = 8,
    parameter int WDATA_DEPTH    = 16,
    parameter int RTAG_DEPTH     = 64,
    parameter int FRAME_WIDTH    = AXI_ADDR_WIDTH + AXI_DATA_WIDTH + 3
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      mc_work_en,
    input  logic                      axi_awvalid,
    output logic                      axi_awready,
    input  logic [AXI_LEN_WIDTH-1:0]  axi_awlen,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_awaddr,
    input  logic                      axi_wvalid,
    output logic                      axi_wready,
    input  logic                      axi_wlast,
    input  logic [AXI_DATA_WIDTH-1:0] axi_wdata,
    input  logic                      axi_arvalid,
    output logic                      axi_arready,
    input  logic [AXI_LEN_WIDTH-1:0]  axi_arlen,
    input  logic [AXI_ADDR_WIDTH-1:0] axi_araddr,
    output logic                      axi_rvalid,
    output logic                      axi_rlast,
    output logic [AXI_DATA_WIDTH-1:0] axi_rdata,
    output logic [FRAME_WIDTH-1:0]    axi_frame_data,
    output logic                      axi_frame_valid,
    input  logic                      axi_frame_ready,
    input  logic [AXI_DATA_WIDTH-1:0] array_rdata,
    input  logic                      array_rvalid,
    output logic                      wlast_err,
    output logic                      rtag_err
);
    localparam int CMD_W = AXI_LEN_WIDTH + AXI_ADDR_WIDTH;
    state_t state, state_n;
    logic prio;
    logic [AXI_LEN_WIDTH-1:0] burst_len, beat_cnt;
    logic [AXI_ADDR_WIDTH-1:0] curr_addr;
    logic [CMD_W-1:0] aw_head, ar_head;
    logic [AXI_DATA_WIDTH:0] w_head;
    logic aw_full, aw_empty, ar_full, ar_empty, w_full, w_empty;
    logic rtag_head, rtag_full, rtag_empty;
    logic is_last, active, sel_w, xfer, aw_pop, ar_pop, w_pop, rtag_push;
    logic [FLAG_WIDTH-1:0] flags;

    sync_fifo #(.DATA_WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_aw (
        .clk(clk), .rstn(rstn), .push(axi_awvalid && axi_awready), .din({axi_awlen, axi_awaddr}),
        .pop(aw_pop), .dout(aw_head), .full(aw_full), .empty(aw_empty)
    );
    sync_fifo #(.DATA_WIDTH(CMD_W), .DEPTH(CMD_DEPTH)) u_ar (
        .clk(clk), .rstn(rstn), .push(axi_arvalid && axi_arready), .din({axi_arlen, axi_araddr}),
        .pop(ar_pop), .dout(ar_head), .full(ar_full), .empty(ar_empty)
    );
    sync_fifo #(.DATA_WIDTH(AXI_DATA_WIDTH + 1), .DEPTH(WDATA_DEPTH)) u_w (
        .clk(clk), .rstn(rstn), .push(axi_wvalid && axi_wready), .din({axi_wlast, axi_wdata}),
        .pop(w_pop), .dout(w_head), .full(w_full), .empty(w_empty)
    );
    sync_fifo #(.DATA_WIDTH(1), .DEPTH(RTAG_DEPTH)) u_rtag (
        .clk(clk), .rstn(rstn), .push(rtag_push), .din(is_last),
        .pop(array_rvalid), .dout(rtag_head), .full(rtag_full), .empty(rtag_empty)
    );

    assign axi_awready = !aw_full;
    assign axi_arready = !ar_full;
    assign axi_wready  = !w_full;
    assign axi_rvalid  = array_rvalid;
    assign axi_rdata   = array_rdata;
    assign axi_rlast   = array_rvalid && !rtag_empty && rtag_head;

    assign is_last   = beat_cnt == burst_len;
    assign active    = state == WDATA || state == RSEND;
    assign sel_w     = !aw_empty && (ar_empty || !prio);
    assign aw_pop    = state == WCMD;
    assign ar_pop    = state == RCMD;
    assign xfer      = axi_frame_valid && axi_frame_ready;
    assign w_pop     = xfer && state == WDATA;
    assign rtag_push = xfer && state == RSEND;

    always_comb begin
        axi_frame_valid = state == WDATA ? !w_empty : state == RSEND ? !rtag_full : 1'b0;
        flags           = '0;
        flags[SOF_OFS]  = active && (beat_cnt == '0 || curr_addr[COL_WIDTH-1:0] == '0);
        flags[EOF_OFS]  = active && (is_last || &curr_addr[COL_WIDTH-1:0]);
        flags[WR_OFS]   = state == WDATA;
        axi_frame_data  = {flags, curr_addr, state == WDATA ? w_head[AXI_DATA_WIDTH-1:0] : '0};
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (mc_work_en && !(aw_empty && ar_empty)) state_n = sel_w ? WCMD : RCMD;
            WCMD:    state_n = WDATA;
            RCMD:    state_n = RSEND;
            default: if (xfer && is_last) state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            prio      <= 1'b0;
            burst_len <= '0;
            curr_addr <= '0;
            beat_cnt  <= '0;
            wlast_err <= 1'b0;
            rtag_err  <= 1'b0;
        end else begin
            // Fairness only matters when both sides compete for the grant.
            if (state == IDLE && state_n != IDLE && !aw_empty && !ar_empty) prio <= !prio;
            if (aw_pop || ar_pop) begin
                {burst_len, curr_addr} <= aw_pop ? aw_head : ar_head;
                beat_cnt <= '0;
            end else if (xfer) begin
                curr_addr <= curr_addr + 1'b1;
                beat_cnt  <= beat_cnt + 1'b1;
            end
            if (w_pop && w_head[AXI_DATA_WIDTH] != is_last) wlast_err <= 1'b1;
            if (array_rvalid && rtag_empty) rtag_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axi_slave_gen2.sv
// tb_axi_slave_gen2: randomized self-checking bench comparing frames and rlast tags
// against a burst-level reference model.
module tb_axi_slave_gen2;
    logic clk = 1'b0;
    logic rstn, mc_work_en;
    logic axi_awvalid, axi_awready, axi_wvalid, axi_wready, axi_wlast;
    logic axi_arvalid, axi_arready, axi_rvalid, axi_rlast;
    logic [5:0] axi_awlen, axi_arlen;
    logic [19:0] axi_awaddr, axi_araddr;
    logic [63:0] axi_wdata, axi_rdata, array_rdata;
    logic [86:0] axi_frame_data;
    logic axi_frame_valid, axi_frame_ready, array_rvalid, wlast_err, rtag_err;

    int vectors = 0;
    int miscompares = 0;
    int rdy_mode = 0;
    logic [86:0] got[$];
    logic [86:0] exp[$];
    logic [63:0] wd[$];
    bit rq[$];

    axi_slave_gen2 dut (
        .clk(clk), .rstn(rstn), .mc_work_en(mc_work_en),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready), .axi_awlen(axi_awlen), .axi_awaddr(axi_awaddr),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_wlast(axi_wlast), .axi_wdata(axi_wdata),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arlen(axi_arlen), .axi_araddr(axi_araddr),
        .axi_rvalid(axi_rvalid), .axi_rlast(axi_rlast), .axi_rdata(axi_rdata),
        .axi_frame_data(axi_frame_data), .axi_frame_valid(axi_frame_valid), .axi_frame_ready(axi_frame_ready),
        .array_rdata(array_rdata), .array_rvalid(array_rvalid), .wlast_err(wlast_err), .rtag_err(rtag_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (rstn && axi_frame_valid && axi_frame_ready) got.push_back(axi_frame_data);

    task automatic tick();
        @(posedge clk);
        #1;
        axi_frame_ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 2 ? 1'b0 : 1'($urandom_range(0, 1));
    endtask

    // Expected frames of one burst: one per beat, sof/eof at burst ends and column boundaries.
    function automatic void model_burst(input bit wr, input logic [19:0] a, input int len);
        for (int i = 0; i <= len; i++) begin
            logic [19:0] ad;
            bit sof, eof;
            ad  = a + 20'(i);
            sof = (i == 0) || (ad % 64 == 0);
            eof = (i == len) || (ad % 64 == 63);
            exp.push_back({sof, eof, wr, ad, wr ? wd[i] : 64'd0});
            if (!wr) rq.push_back(i == len);
        end
    endfunction

    task automatic aw_cmd(input logic [19:0] a, input int len);
        axi_awvalid = 1'b1; axi_awaddr = a; axi_awlen = 6'(len);
        for (int c = 0; c < 2000 && !axi_awready; c++) tick();
        tick();
        axi_awvalid = 1'b0;
    endtask

    task automatic ar_cmd(input logic [19:0] a, input int len);
        axi_arvalid = 1'b1; axi_araddr = a; axi_arlen = 6'(len);
        for (int c = 0; c < 2000 && !axi_arready; c++) tick();
        tick();
        axi_arvalid = 1'b0;
    endtask

    task automatic w_beat(input logic [63:0] d, input bit last);
        axi_wvalid = 1'b1; axi_wdata = d; axi_wlast = last;
        for (int c = 0; c < 2000 && !axi_wready; c++) tick();
        tick();
        axi_wvalid = 1'b0;
    endtask

    task automatic do_write(input logic [19:0] a, input int len, input int bad);
        wd.delete();
        for (int i = 0; i <= len; i++) wd.push_back({$urandom, $urandom});
        model_burst(1'b1, a, len);
        aw_cmd(a, len);
        for (int i = 0; i <= len; i++) w_beat(wd[i], (i == len) ^ (i == bad));
    endtask

    task automatic do_read(input logic [19:0] a, input int len);
        model_burst(1'b0, a, len);
        ar_cmd(a, len);
    endtask

    task automatic wait_frames();
        for (int c = 0; c < 4000 && got.size() < exp.size(); c++) tick();
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0; mc_work_en = 1'b1; axi_frame_ready = 1'b1;
        axi_awvalid = 0; axi_wvalid = 0; axi_arvalid = 0; axi_wlast = 0;
        axi_awlen = 0; axi_arlen = 0; axi_awaddr = 0; axi_araddr = 0; axi_wdata = 0;
        array_rvalid = 1'b1; array_rdata = 64'h1234;
        repeat (3) tick();
        vectors++;
        if (axi_frame_valid !== 1'b0 || axi_rvalid !== 1'b1 || axi_rlast !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs: valid=%b rvalid=%b rlast=%b required 0 1 0", axi_frame_valid, axi_rvalid, axi_rlast);
        end
        array_rvalid = 1'b0;
        rstn = 1'b1;
        tick();
        vectors++;
        if ({axi_awready, axi_wready, axi_arready, wlast_err, rtag_err, axi_frame_valid} !== 6'b111000) begin
            miscompares++;
            $display("FAIL reset_state: rdy/err/valid=%b required 111000",
                     {axi_awready, axi_wready, axi_arready, wlast_err, rtag_err, axi_frame_valid});
        end
    endtask

    task automatic test_write_burst();
        got.delete(); exp.delete();
        do_write(20'h00010, 3, -1);
        wait_frames();
        vectors++;
        if (got.size() != 4) begin
            miscompares++;
            $display("FAIL write_count: got %0d frames required 4", got.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            vectors++;
            if (got[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL write_frame%0d: got %h required %h", i, got[i], exp[i]);
            end
        end
    endtask

    task automatic test_read_split();
        got.delete(); exp.delete(); rq.delete();
        do_read(20'h0003E, 3);
        wait_frames();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (got[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL read_frame%0d: got %h required %h", i, got[i], exp[i]);
            end
        end
        for (int i = 0; i < 4; i++) begin
            array_rvalid = 1'b1; array_rdata = {$urandom, $urandom};
            #1;
            vectors++;
            if (axi_rvalid !== 1'b1 || axi_rlast !== (i == 3) || axi_rdata !== array_rdata) begin
                miscompares++;
                $display("FAIL read_rlast%0d: rvalid=%b rlast=%b required 1 %b", i, axi_rvalid, axi_rlast, i == 3);
            end
            tick();
        end
        array_rvalid = 1'b0;
        rq.delete();
    endtask

    task automatic test_reset_midburst();
        got.delete(); exp.delete();
        rdy_mode = 2;
        tick();
        aw_cmd(20'h00800, 3);
        w_beat(64'hAAAA, 1'b0);
        w_beat(64'hBBBB, 1'b0);
        repeat (3) tick();
        vectors++;
        if (axi_frame_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midburst_valid: got %b required 1", axi_frame_valid);
        end
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        rdy_mode = 0;
        tick();
        repeat (5) tick();
        vectors++;
        if (axi_frame_valid !== 1'b0 || got.size() != 0 || axi_awready !== 1'b1 || axi_wready !== 1'b1) begin
            miscompares++;
            $display("FAIL midburst_discard: valid=%b frames=%0d awready=%b wready=%b required 0 0 1 1",
                     axi_frame_valid, got.size(), axi_awready, axi_wready);
        end
    endtask

    task automatic test_arbitration();
        got.delete(); exp.delete(); rq.delete();
        mc_work_en = 1'b0;
        do_write(20'h00100, 0, -1);
        do_read(20'h00200, 0);
        do_write(20'h00300, 0, -1);
        do_read(20'h00400, 0);
        mc_work_en = 1'b1;
        wait_frames();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (got[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL arb_grant%0d: got %h required %h", i, got[i], exp[i]);
            end
        end
        for (int i = 0; i < 2; i++) begin
            array_rvalid = 1'b1;
            #1;
            vectors++;
            if (axi_rlast !== 1'b1) begin
                miscompares++;
                $display("FAIL arb_rlast%0d: got %b required 1", i, axi_rlast);
            end
            tick();
        end
        array_rvalid = 1'b0;
        rq.delete();
    endtask

    task automatic test_work_en();
        got.delete(); exp.delete();
        mc_work_en = 1'b0;
        do_write(20'h00500, 3, -1);
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (axi_frame_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL en_hold%0d: valid=%b required 0", i, axi_frame_valid);
            end
        end
        mc_work_en = 1'b1;
        tick();
        vectors++;
        if (axi_frame_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL en_cmd_cycle: valid=%b required 0", axi_frame_valid);
        end
        tick();
        vectors++;
        if (axi_frame_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL en_first_beat: valid=%b required 1", axi_frame_valid);
        end
        tick();
        mc_work_en = 1'b0;
        wait_frames();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (got[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL en_drop_frame%0d: got %h required %h", i, got[i], exp[i]);
            end
        end
        got.delete(); exp.delete();
        do_write(20'h00600, 0, -1);
        repeat (5) tick();
        vectors++;
        if (axi_frame_valid !== 1'b0 || got.size() != 0) begin
            miscompares++;
            $display("FAIL en_idle_hold: valid=%b frames=%0d required 0 0", axi_frame_valid, got.size());
        end
        mc_work_en = 1'b1;
        wait_frames();
        vectors++;
        if (got.size() != 1 || got[0] !== exp[0]) begin
            miscompares++;
            $display("FAIL en_resume: got %h (%0d frames) required %h", got[0], got.size(), exp[0]);
        end
    endtask

    task automatic test_errors();
        got.delete(); exp.delete(); rq.delete();
        vectors++;
        if (wlast_err !== 1'b0 || rtag_err !== 1'b0) begin
            miscompares++;
            $display("FAIL err_clear: wlast_err=%b rtag_err=%b required 0 0", wlast_err, rtag_err);
        end
        do_write(20'h00700, 3, 1);
        wait_frames();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (got[i] !== exp[i]) begin
                miscompares++;
                $display("FAIL err_frame%0d: got %h required %h", i, got[i], exp[i]);
            end
        end
        repeat (5) tick();
        vectors++;
        if (wlast_err !== 1'b1) begin
            miscompares++;
            $display("FAIL wlast_err_sticky: got %b required 1", wlast_err);
        end
        array_rvalid = 1'b1;
        #1;
        vectors++;
        if (axi_rvalid !== 1'b1 || axi_rlast !== 1'b0) begin
            miscompares++;
            $display("FAIL orphan_rvalid: rvalid=%b rlast=%b required 1 0", axi_rvalid, axi_rlast);
        end
        tick();
        array_rvalid = 1'b0;
        repeat (2) tick();
        vectors++;
        if (rtag_err !== 1'b1) begin
            miscompares++;
            $display("FAIL rtag_err: got %b required 1", rtag_err);
        end
        got.delete(); exp.delete();
        do_read(20'h00720, 1);
        wait_frames();
        for (int i = 0; i < 2; i++) begin
            array_rvalid = 1'b1;
            #1;
            vectors++;
            if (axi_rlast !== rq[i]) begin
                miscompares++;
                $display("FAIL rtag_after_err%0d: rlast=%b required %b", i, axi_rlast, rq[i]);
            end
            tick();
        end
        array_rvalid = 1'b0;
        rq.delete();
    endtask

    task automatic test_random();
        rdy_mode = 1;
        for (int n = 0; n < 30; n++) begin
            logic [19:0] a;
            int len;
            bit wr;
            got.delete(); exp.delete(); rq.delete();
            a   = n == 0 ? 20'hFFFFE : 20'($urandom);
            if (n > 0 && $urandom_range(0, 3) == 0) a = {a[19:6], 6'(60 + $urandom_range(0, 3))};
            len = n == 0 ? 3 : int'($urandom_range(0, 40));
            wr  = n == 0 ? 1'b1 : 1'($urandom_range(0, 1));
            if (wr) do_write(a, len, -1);
            else do_read(a, len);
            wait_frames();
            vectors++;
            if (got.size() != exp.size()) begin
                miscompares++;
                $display("FAIL rand%0d_count: got %0d frames required %0d", n, got.size(), exp.size());
            end
            for (int i = 0; i < exp.size(); i++) begin
                vectors++;
                if (got[i] !== exp[i]) begin
                    miscompares++;
                    $display("FAIL rand%0d_frame%0d: got %h required %h", n, i, got[i], exp[i]);
                end
            end
            for (int c = 0; c < 2000 && rq.size() > 0; c++) begin
                array_rvalid = 1'($urandom_range(0, 1));
                array_rdata  = {$urandom, $urandom};
                #1;
                if (array_rvalid) begin
                    vectors++;
                    if (axi_rvalid !== 1'b1 || axi_rlast !== rq[0] || axi_rdata !== array_rdata) begin
                        miscompares++;
                        $display("FAIL rand%0d_rtag: rvalid=%b rlast=%b required 1 %b", n, axi_rvalid, axi_rlast, rq[0]);
                    end
                    void'(rq.pop_front());
                end
                tick();
            end
            array_rvalid = 1'b0;
        end
        rdy_mode = 0;
    endtask

    initial begin
        test_reset();
        test_write_burst();
        test_read_split();
        test_reset_midburst();
        test_arbitration();
        test_work_en();
        test_errors();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
